// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for three requesters (ALU, MEM, LINK) feeding a one-entry register-file write buffer,
// with a busy-register scoreboard and an acknowledge checker. Define WB_ARB_RR_EN for round-robin arbitration.
module regfile_wb_arbiter (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_valid,
  input  logic [2:0][2:0]  req_dest,
  input  logic [2:0][15:0] req_data,
  output logic [2:0]       req_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic             sb_set,
  input  logic [2:0]       sb_dest,
  input  logic [2:0]       rs_q,
  input  logic [2:0]       rt_q,
  output logic             hz_rs,
  output logic             hz_rt,
  output logic             wr,
  output logic [2:0]       dest_out,
  output logic [15:0]      data_out,
  input  logic             wr_success,
  output logic             ack_err
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t buf_state;
  logic [7:0] busy;
  logic [7:0] busy_next;
  logic [1:0] ptr;
  logic [1:0] gnt_idx;
  logic       can_grant;
  logic       transfer;
  logic       wr_q;

  assign wr = (buf_state == FULL) && !stall;

  // rst gates grants so req_ready stays low while reset is held.
  assign can_grant = rst && !stall && !flush && ((buf_state == EMPTY) || wr);

`ifdef WB_ARB_RR_EN
  logic [2:0] sum;
  logic [1:0] cand;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    req_ready = '0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    if (can_grant) begin
      for (int k = 1; k <= 3; k++) begin
        sum  = {1'b0, ptr} + 3'(k);
        cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (req_valid[cand] && (req_ready == 3'b000)) begin
          req_ready[cand] = 1'b1;
          gnt_idx         = cand;
        end
      end
    end
  end
`else
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    if (can_grant) begin
      if (req_valid[2]) begin
        req_ready = 3'b100;
        gnt_idx   = 2'd2;
      end else if (req_valid[1]) begin
        req_ready = 3'b010;
        gnt_idx   = 2'd1;
      end else if (req_valid[0]) begin
        req_ready = 3'b001;
        gnt_idx   = 2'd0;
      end
    end
  end
`endif

  assign transfer = |req_ready;

  // A stalled cycle has neither a transfer nor a wr, so the buffer simply holds.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments; the async reset also clears the buffer contents.
    if (!rst) begin
      buf_state <= EMPTY;
      dest_out  <= '0;
      data_out  <= '0;
      ptr       <= 2'd2;
    end else if (flush) begin
      buf_state <= EMPTY;
    end else if (transfer) begin
      buf_state <= FULL;
      dest_out  <= req_dest[gnt_idx];
      data_out  <= req_data[gnt_idx];
      ptr       <= gnt_idx;
    end else if (wr) begin
      buf_state <= EMPTY;
    end
  end

  // Set is applied after clear so an issue to the register being retired keeps it busy.
  always_comb begin
    busy_next = busy;
    if (wr)     busy_next[dest_out] = 1'b0;
    if (sb_set) busy_next[sb_dest]  = 1'b1;
    if (flush)  busy_next           = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  assign hz_rs = busy[rs_q];
  assign hz_rt = busy[rt_q];

  // The regfile acks one cycle after each write; any disagreement latches ack_err until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      wr_q <= wr;
      if (wr_q != wr_success) ack_err <= 1'b1;
    end
  end

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst) ptr != 2'd3);

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 3: write-back request per requester (0=ALU, 1=MEM, 2=LINK).
REQ-004 SHALL have port req_dest, input, 3x3: destination register per requester.
REQ-005 SHALL have port req_data, input, 3x16: write data per requester.
REQ-006 SHALL have port req_ready, output, 3: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have port stall, input, 1: freezes the write port.
REQ-008 SHALL have port flush, input, 1: exception flush; drops buffered write and clears the scoreboard.
REQ-009 SHALL have port sb_set, input, 1, and port sb_dest, input, 3: mark a register as write-pending at issue.
REQ-010 SHALL have port rs_q, input, 3, and port rt_q, input, 3: hazard query addresses.
REQ-011 SHALL have port hz_rs, output, 1, and port hz_rt, output, 1: pending status of rs_q and rt_q.
REQ-012 SHALL have port wr, output, 1; port dest_out, output, 3; and port data_out, output, 16: regfile write port.
REQ-013 SHALL have port wr_success, input, 1: regfile acknowledge, registered by the regfile.
REQ-014 SHALL have port ack_err, output, 1: sticky acknowledge-mismatch flag.

Function
REQ-015 SHALL hold a one-entry output buffer (FULL/EMPTY); wr SHALL equal FULL && !stall; dest_out and data_out SHALL come straight from the buffer.
REQ-016 SHALL grant at most one requester per cycle, and only when !stall && !flush && (EMPTY || wr).
REQ-017 req_ready SHALL be combinational from the current req_valid and arbitration state; req_ready SHALL be 0 for requesters that are not valid.
REQ-018 On a transfer in cycle N, the buffer SHALL load dest and data, and wr SHALL be high in cycle N+1 unless stall is high; sustained throughput SHALL be one write per cycle.
REQ-019 While stall is high, the buffer SHALL hold its contents, wr SHALL be 0, and all req_ready SHALL be 0.
REQ-020 Scoreboard: 8 busy bits; sb_set SHALL set busy[sb_dest]; a cycle with wr high SHALL clear busy[dest_out].
REQ-021 If set and clear target the same register in the same cycle, set SHALL win.
REQ-022 hz_rs SHALL equal busy[rs_q] and hz_rt SHALL equal busy[rt_q], combinationally, with no bypass of same-cycle sb_set.
REQ-023 flush SHALL, on the next edge, empty the buffer and clear all busy bits; no grant SHALL occur in the flush cycle; flush SHALL override sb_set and stall.
REQ-024 ack_err SHALL set if wr was high in cycle N and wr_success is low in cycle N+1, or if wr_success is high without a preceding wr; ack_err SHALL clear only on reset.
REQ-025 A 2-bit grant pointer SHALL record the last granted requester, holding values 0..2 and wrapping from 2 to 0.

Reset
REQ-026 Reset SHALL take effect asynchronously on rst low and release synchronously.
REQ-027 During reset: buffer EMPTY, wr=0, dest_out=0, data_out=0, busy=0, ack_err=0, pointer=2 (so requester 0 wins first under round-robin), req_ready=0.
REQ-028 Reset asserted mid-transfer SHALL drop the buffered write with no wr pulse.

Configuration
REQ-029 With WB_ARB_RR_EN defined: round-robin arbitration, search order starting at pointer+1 mod 3; pointer SHALL update on each transfer.
REQ-030 Without WB_ARB_RR_EN: fixed priority LINK > MEM > ALU; the pointer SHALL still update but SHALL not affect the grant.

Verification
REQ-031 ALU valid, dest=3, data=16'h1234, idle -> req_ready=3'b001 same cycle; next cycle wr=1, dest_out=3, data_out=16'h1234.
REQ-032 All three valid for 6 cycles, RR_EN defined -> grant order 0,1,2,0,1,2; macro undefined -> 2,2,2,2,2,2.
REQ-033 sb_set with dest=5, then MEM write to dest=5 -> hz_rs high (rs_q=5) until the cycle after wr; simultaneous sb_set 5 and wr 5 -> busy[5] remains 1.
REQ-034 Buffer full, stall held 3 cycles -> wr=0 and req_ready=0 throughout, data held; stall released -> wr=1 with original data.
REQ-035 flush with buffer full and busy=8'hFF -> next cycle wr=0, busy=0, hz_rs=0; rst low mid-transfer -> no wr pulse, all outputs 0.
REQ-036 wr pulse followed by wr_success=0 -> ack_err=1 and stays set until rst.
